// File: rtl/eda_result_pkg.sv
// Shared geometry, widths and FSM state type for the regional-max result reader.
// Geometry defaults may be overridden with `CFG_M / `CFG_N / `CFG_I_WIDTH.
`ifndef CFG_M
`define CFG_M 16
`endif
`ifndef CFG_N
`define CFG_N 16
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 4
`endif

package eda_result_pkg;
   localparam int M_DEF       = `CFG_M;
   localparam int N_DEF       = `CFG_N;
   localparam int I_WIDTH_DEF = `CFG_I_WIDTH;
   localparam int ROW_CNT_W   = $clog2(N_DEF + 1);
   localparam int FRAME_CNT_W = $clog2(M_DEF * N_DEF + 1);

   typedef logic [N_DEF-1:0] row_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } state_t;
endpackage

// File: rtl/eda_result_reader_if.sv
// Row-beat stream from the result reader to the downstream sink (valid/ready).
// With EDA_RESULT_POPCOUNT_EN the beat also carries row_count.
interface eda_result_reader_if
   import eda_result_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int I_WIDTH = I_WIDTH_DEF
);
   logic               row_valid;
   logic               row_ready;
   logic [N-1:0]       row_data;
   logic [I_WIDTH-1:0] row_idx;
   logic               row_last;
`ifdef EDA_RESULT_POPCOUNT_EN
   logic [$clog2(N+1)-1:0] row_count;

   modport master (output row_valid, row_data, row_idx, row_last, row_count, input row_ready);
   modport slave  (input row_valid, row_data, row_idx, row_last, row_count, output row_ready);
`else
   modport master (output row_valid, row_data, row_idx, row_last, input row_ready);
   modport slave  (input row_valid, row_data, row_idx, row_last, output row_ready);
`endif
endinterface

// File: rtl/eda_row_popcount.sv
// Combinational population count of one result row; only built with EDA_RESULT_POPCOUNT_EN.
`ifdef EDA_RESULT_POPCOUNT_EN
module eda_row_popcount
   import eda_result_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]            row,
   output logic [$clog2(N+1)-1:0]  count
);
   localparam int CW = $clog2(N + 1);

   // Bit-serial sum, unrolled by synthesis into an adder tree
   always_comb begin
      count = {CW{1'b0}};
      for (int i = 0; i < N; i++) begin
         count = count + CW'(row[i]);
      end
   end
endmodule
`endif

// File: rtl/eda_result_reader.sv
// Snapshots the regional-max map on each done rise and streams it one row per beat.
// Optional EDA_RESULT_POPCOUNT_EN adds per-row and per-frame set-bit counts.
module eda_result_reader
   import eda_result_pkg::*;
#(
   parameter int M       = M_DEF,
   parameter int N       = N_DEF,
   parameter int I_WIDTH = I_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  done,
   input  logic [M-1:0][N-1:0]   matrix_output,
   eda_result_reader_if.master   row_if,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun,
   input  logic                  clear_err
`ifdef EDA_RESULT_POPCOUNT_EN
   ,
   output logic [$clog2(M*N+1)-1:0] frame_count
`endif
);
   localparam logic [I_WIDTH-1:0] LAST_IDX = I_WIDTH'(M - 1);

   state_t               state_r;
   logic                 done_d_r;
   logic [I_WIDTH-1:0]   cnt_r;
   logic [M-1:0][N-1:0]  snapshot_r;
   logic                 row_valid_r;
   logic [N-1:0]         row_data_r;
   logic                 row_last_r;
   logic                 busy_r;
   logic                 frame_done_r;
   logic                 overrun_r;

   logic                 done_rise_s;
   logic [I_WIDTH-1:0]   cnt_nxt_s;
   logic [N-1:0]         row_next_s;

`ifdef EDA_RESULT_POPCOUNT_EN
   localparam int RC_W = $clog2(N + 1);
   localparam int FC_W = $clog2(M * N + 1);
   logic [RC_W-1:0] row_count_r;
   logic [RC_W-1:0] pc_next_s;
   logic [FC_W-1:0] frame_count_r;

   eda_row_popcount #(.N(N)) u_popcount (
      .row   (row_next_s),
      .count (pc_next_s)
   );
`endif

   // Rise detect and the row that the next loaded beat will carry
   always_comb begin
      done_rise_s = done & ~done_d_r;
      cnt_nxt_s   = cnt_r + I_WIDTH'(1);
      if ((state_r == SEND) && (cnt_r != LAST_IDX)) begin
         row_next_s = snapshot_r[cnt_nxt_s];
      end else begin
         row_next_s = matrix_output[0];
      end
   end

   // Capture/stream sequencer; every output is a register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         done_d_r     <= 1'b0;
         cnt_r        <= {I_WIDTH{1'b0}};
         snapshot_r   <= '0;
         row_valid_r  <= 1'b0;
         row_data_r   <= {N{1'b0}};
         row_last_r   <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         overrun_r    <= 1'b0;
`ifdef EDA_RESULT_POPCOUNT_EN
         row_count_r   <= {RC_W{1'b0}};
         frame_count_r <= {FC_W{1'b0}};
`endif
      end else begin
         done_d_r     <= done;
         frame_done_r <= 1'b0;

         // A rise while a frame is in flight is dropped and flagged; set beats clear
         if (done_rise_s && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
         end else if (clear_err) begin
            overrun_r <= 1'b0;
         end else begin
            overrun_r <= overrun_r;
         end

         case (state_r)
            IDLE: begin
               if (done_rise_s) begin
                  snapshot_r  <= matrix_output;
                  cnt_r       <= {I_WIDTH{1'b0}};
                  row_data_r  <= row_next_s;
                  row_last_r  <= (LAST_IDX == {I_WIDTH{1'b0}});
                  row_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= SEND;
`ifdef EDA_RESULT_POPCOUNT_EN
                  row_count_r   <= pc_next_s;
                  frame_count_r <= {FC_W{1'b0}};
`endif
               end
            end
            SEND: begin
               if (row_valid_r && row_if.row_ready) begin
`ifdef EDA_RESULT_POPCOUNT_EN
                  frame_count_r <= frame_count_r + FC_W'(row_count_r);
`endif
                  if (cnt_r == LAST_IDX) begin
                     row_valid_r <= 1'b0;
                     state_r     <= FIN;
                  end else begin
                     cnt_r      <= cnt_nxt_s;
                     row_data_r <= row_next_s;
                     row_last_r <= (cnt_nxt_s == LAST_IDX);
`ifdef EDA_RESULT_POPCOUNT_EN
                     row_count_r <= pc_next_s;
`endif
                  end
               end
            end
            FIN: begin
               frame_done_r <= 1'b1;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               row_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign row_if.row_valid = row_valid_r;
   assign row_if.row_data  = row_data_r;
   assign row_if.row_idx   = cnt_r;
   assign row_if.row_last  = row_last_r;
   assign busy             = busy_r;
   assign frame_done       = frame_done_r;
   assign overrun          = overrun_r;
`ifdef EDA_RESULT_POPCOUNT_EN
   assign row_if.row_count = row_count_r;
   assign frame_count      = frame_count_r;
`endif
endmodule

// File: tb/tb_eda_result_reader.sv
// Directed, table-driven bench for eda_result_reader (M = N = 16).
module tb_eda_result_reader;
   import eda_result_pkg::*;

   localparam int M  = 16;
   localparam int N  = 16;
   localparam int IW = 4;

   logic                clk;
   logic                reset_n;
   logic                done;
   logic [M-1:0][N-1:0] mo;
   logic                busy, frame_done, overrun, clear_err;
`ifdef EDA_RESULT_POPCOUNT_EN
   logic [$clog2(M*N+1)-1:0] frame_count;
`endif

   eda_result_reader_if #(.N(N), .I_WIDTH(IW)) rif ();

   eda_result_reader #(.M(M), .N(N), .I_WIDTH(IW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .done          (done),
      .matrix_output (mo),
      .row_if        (rif),
      .busy          (busy),
      .frame_done    (frame_done),
      .overrun       (overrun),
      .clear_err     (clear_err)
`ifdef EDA_RESULT_POPCOUNT_EN
      ,
      .frame_count   (frame_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [M-1:0][N-1:0] map;
      logic [3:0]          ready_pat;  // ready in stream cycle c is ready_pat[c%4]
      int                  hold;       // cycles done stays high
      int                  iso_n;      // edge after which matrix_output goes all-ones (0 = never)
      int                  ovr_n;      // edge after which a second done pulse starts (-10 = never)
      int                  exp_lat;    // cycles from capture edge to frame_done
      logic                exp_ovr;
   } vec_t;

   vec_t vecs [6];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_frame(input int v);
      logic [N-1:0] prev_data;
      logic [IW-1:0] prev_idx;
      logic prev_stall;
      logic seen_fd;
      int beats, lat, exp_fc, extra;
      beats = 0; lat = -1; exp_fc = 0; prev_stall = 1'b0; seen_fd = 1'b0;
      prev_data = '0; prev_idx = '0;
      mo = vecs[v].map;
      done = 1'b1;
      rif.row_ready = vecs[v].ready_pat[0];
      for (int n = 1; n <= 120 && !seen_fd; n++) begin
         step();
         if (n == vecs[v].hold) done = 1'b0;
         if (n == vecs[v].ovr_n) done = 1'b1;
         if (n == vecs[v].ovr_n + 1) done = 1'b0;
         if (n == vecs[v].iso_n) mo = {(M*N){1'b1}};
         rif.row_ready = vecs[v].ready_pat[(n-1)%4];
         if (n == 1) begin
            chk("first_valid", rif.row_valid, 1);
            chk("first_busy", busy, 1);
            chk("first_idx", rif.row_idx, 0);
         end
         if (prev_stall) begin
            chk("stall_valid", rif.row_valid, 1);
            chk("stall_data", rif.row_data, prev_data);
            chk("stall_idx", rif.row_idx, prev_idx);
         end
         if (frame_done) begin
            seen_fd = 1'b1;
            lat = n - 1;
         end
         if (rif.row_valid && beats < M) begin
            if (rif.row_ready) begin
               chk("row_idx", rif.row_idx, beats);
               chk("row_data", rif.row_data, vecs[v].map[beats]);
               chk("row_last", rif.row_last, (beats == M-1));
`ifdef EDA_RESULT_POPCOUNT_EN
               chk("row_count", rif.row_count, $countones(vecs[v].map[beats]));
`endif
               exp_fc += $countones(vecs[v].map[beats]);
               beats++;
            end
            prev_stall = !rif.row_ready;
            prev_data  = rif.row_data;
            prev_idx   = rif.row_idx;
         end else begin
            prev_stall = 1'b0;
         end
      end
      chk("frame_latency", lat, vecs[v].exp_lat);
      chk("beat_count", beats, M);
      chk("busy_after", busy, 0);
      chk("overrun_after", overrun, vecs[v].exp_ovr);
`ifdef EDA_RESULT_POPCOUNT_EN
      chk("frame_count", frame_count, exp_fc);
`endif
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (rif.row_valid || frame_done) extra++;
      end
      chk("no_second_frame", extra, 0);
   endtask

   initial begin
      logic [M-1:0][N-1:0] shift_map, rev_map, chk_map;
      int cnt;
      logic got;
      for (int i = 0; i < M; i++) begin
         shift_map[i] = 16'h0001 << i;
         rev_map[i]   = 16'h8000 >> i;
         chk_map[i]   = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
      end
      vecs[0] = '{shift_map,          4'b1111, 5, 0, -10, 17, 1'b0};
      vecs[1] = '{shift_map,          4'b1001, 1, 0, -10, 33, 1'b0};
      vecs[2] = '{shift_map,          4'b1111, 2, 4, -10, 17, 1'b0};
      vecs[3] = '{chk_map,            4'b1111, 1, 0, -10, 17, 1'b0};
      vecs[4] = '{{(M*N){1'b1}},      4'b0101, 3, 0, -10, 32, 1'b0};
      vecs[5] = '{rev_map,            4'b1111, 1, 0,   6, 17, 1'b1};

      reset_n = 1'b0; done = 1'b0; clear_err = 1'b0; rif.row_ready = 1'b0;
      mo = shift_map;
      step(); step();
      chk("rst_valid", rif.row_valid, 0);
      chk("rst_data", rif.row_data, 0);
      chk("rst_idx", rif.row_idx, 0);
      chk("rst_last", rif.row_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overrun", overrun, 0);
      reset_n = 1'b1;
      step(); step();

      for (int v = 0; v < 6; v++) run_frame(v);

      // Overrun from vector 5 clears one cycle after clear_err
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("overrun_cleared", overrun, 0);

      // Coincident clear_err and overrun event: set wins
      rif.row_ready = 1'b0;
      mo = shift_map;
      done = 1'b1; step();
      done = 1'b0; step(); step();
      done = 1'b1; step();
      chk("overrun_set", overrun, 1);
      done = 1'b0; step();
      done = 1'b1; clear_err = 1'b1; step();
      chk("overrun_set_wins", overrun, 1);
      done = 1'b0; step();
      chk("overrun_clear2", overrun, 0);
      clear_err = 1'b0;
      rif.row_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         step();
         if (frame_done) got = 1'b1;
      end
      chk("stalled_frame_done", got, 1);
      step(); step();

      // Reset in the middle of the stream
      mo = shift_map;
      done = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         step();
         done = 1'b0;
         if (rif.row_valid && rif.row_idx == 4'd8) got = 1'b1;
      end
      chk("reached_row8", got, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_valid", rif.row_valid, 0);
      chk("midrst_data", rif.row_data, 0);
      chk("midrst_idx", rif.row_idx, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_last", rif.row_last, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (rif.row_valid) cnt++;
      end
      chk("no_beats_after_reset", cnt, 0);
      run_frame(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
